// File: rtl/trig_sched_pkg.sv
// Shared types and helpers for the trigger fire scheduler.
package trig_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [2:0] SRC_ROLL = 3'd7;

    // Increment that sticks at max instead of wrapping.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input logic [63:0] max);
        return (v == max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/trig_fire_sched_if.sv
// Port bundle between the trigger logic (master) and trig_fire_sched (slave).
// No valid/ready handshake: req is a level, and each rising edge of a bit is one request transaction.
interface trig_fire_sched_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 32
);
    import trig_sched_pkg::*;

    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  req_en;
    logic [31:0]      randnum;
    logic [31:0]      prescale;
    logic             dorolling;
    logic             ext_trig_out;
    logic [2:0]       fire_src;
    logic             busy;
    logic [CNT_W-1:0] cnt_fired;
    logic [CNT_W-1:0] cnt_vetoed;
    logic [CNT_W-1:0] cnt_prescaled;
    state_t           dbg_state;

    modport master (
        output req, req_en, randnum, prescale, dorolling,
        input  ext_trig_out, fire_src, busy, cnt_fired, cnt_vetoed, cnt_prescaled, dbg_state
    );

    modport slave (
        input  req, req_en, randnum, prescale, dorolling,
        output ext_trig_out, fire_src, busy, cnt_fired, cnt_vetoed, cnt_prescaled, dbg_state
    );

endinterface

// File: rtl/trig_roll_timer.sv
// Rolling-trigger timer: counts idle cycles, tick is the top bit of the counter.
module trig_roll_timer #(
    parameter int ROLL_BIT = 25
) (
    input  logic clk_adc,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    logic [ROLL_BIT:0] roll_cnt;

    always_ff @(posedge clk_adc) begin
        if (reset || clear) begin
            roll_cnt <= '0;
        end else if (!hold) begin
            roll_cnt <= roll_cnt + (ROLL_BIT + 1)'(1);
        end
    end

    assign tick = roll_cnt[ROLL_BIT];

endmodule

// File: rtl/trig_fire_sched.sv
// Trigger fire scheduler: arbitrates request edges and the rolling timer onto ext_trig_out.
// Statistics counters exist only when TRIG_SCHED_STATS_EN is defined; otherwise cnt_* read 0.
module trig_fire_sched
    import trig_sched_pkg::*;
#(
    parameter int NREQ        = 4,
    parameter int PULSE_TICKS = 4,
    parameter int DEAD_TICKS  = 20,
    parameter int ROLL_BIT    = 25,
    parameter int CNT_W       = 32
) (
    input logic              clk_adc,
    input logic              reset,
    trig_fire_sched_if.slave bus
);

    localparam int TW = 16;

    logic [NREQ-1:0] req_q, req_qq, edge_q;
    logic [31:0]     prescale_q;
    logic            pass_q;
    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic            ext_trig_r, busy_r;
    logic [2:0]      fire_src_r, win_idx;
    logic            edge_any, idle, roll_tick, fire_hw, fire_roll, pre_rej;

    // The request sync stage keeps sampling through reset, so a level that is
    // already high when reset releases is not mistaken for a new request.
    always_ff @(posedge clk_adc) begin
        req_q  <= bus.req;
        req_qq <= req_q;
    end

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            edge_q     <= '0;
            prescale_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            edge_q     <= req_q & ~req_qq & bus.req_en;
            prescale_q <= bus.prescale;
            pass_q     <= (bus.randnum <= prescale_q);
        end
    end

    // Lowest set index wins; scanning downward leaves it as the last assignment.
    always_comb begin
        win_idx = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (edge_q[i]) win_idx = 3'(i);
        end
    end

    assign edge_any  = |edge_q;
    assign idle      = (state == IDLE);
    assign fire_hw   = idle & edge_any & pass_q;
    assign pre_rej   = idle & edge_any & ~pass_q;
    assign fire_roll = idle & ~edge_any & roll_tick & bus.dorolling;

    trig_roll_timer #(.ROLL_BIT(ROLL_BIT)) u_roll (
        .clk_adc (clk_adc),
        .reset   (reset),
        .clear   (idle & (edge_any | roll_tick)),
        .hold    (~idle),
        .tick    (roll_tick)
    );

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            ext_trig_r <= 1'b0;
            busy_r     <= 1'b0;
            fire_src_r <= 3'd0;
        end else begin
            ext_trig_r <= (state == FIRE);
            tick_cnt   <= tick_cnt + TW'(1);
            case (state)
                IDLE: begin
                    tick_cnt <= '0;
                    if (fire_hw || fire_roll) begin
                        state      <= FIRE;
                        busy_r     <= 1'b1;
                        fire_src_r <= fire_hw ? win_idx : SRC_ROLL;
                    end else if (pre_rej && DEAD_TICKS != 0) begin
                        state  <= DEAD;
                        busy_r <= 1'b1;
                    end
                end
                FIRE: begin
                    if (tick_cnt == TW'(PULSE_TICKS - 1)) begin
                        tick_cnt <= '0;
                        if (DEAD_TICKS == 0) begin
                            state  <= IDLE;
                            busy_r <= 1'b0;
                        end else begin
                            state <= DEAD;
                        end
                    end
                end
                DEAD: begin
                    if (tick_cnt == TW'(DEAD_TICKS - 1)) begin
                        tick_cnt <= '0;
                        state    <= IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ext_trig_out = ext_trig_r;
    assign bus.fire_src     = fire_src_r;
    assign bus.busy         = busy_r;
    assign bus.dbg_state    = state;

`ifdef TRIG_SCHED_STATS_EN
    localparam logic [63:0] CNT_MAX = (CNT_W >= 64) ? {64{1'b1}} : ((64'd1 << CNT_W) - 64'd1);

    logic [CNT_W-1:0] cnt_fired_r, cnt_vetoed_r, cnt_prescaled_r;

    always_ff @(posedge clk_adc) begin
        if (reset) begin
            cnt_fired_r     <= '0;
            cnt_vetoed_r    <= '0;
            cnt_prescaled_r <= '0;
        end else begin
            if (fire_hw || fire_roll)
                cnt_fired_r <= CNT_W'(sat_inc(64'(cnt_fired_r), CNT_MAX));
            if (pre_rej)
                cnt_prescaled_r <= CNT_W'(sat_inc(64'(cnt_prescaled_r), CNT_MAX));
            // One veto per busy cycle with any edge, however many bits are set.
            if (!idle && edge_any)
                cnt_vetoed_r <= CNT_W'(sat_inc(64'(cnt_vetoed_r), CNT_MAX));
        end
    end

    assign bus.cnt_fired     = cnt_fired_r;
    assign bus.cnt_vetoed    = cnt_vetoed_r;
    assign bus.cnt_prescaled = cnt_prescaled_r;
`else
    assign bus.cnt_fired     = {CNT_W{1'b0}};
    assign bus.cnt_vetoed    = {CNT_W{1'b0}};
    assign bus.cnt_prescaled = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_trig_fire_sched.sv
// Bench for trig_fire_sched: directed scenarios with literal expectations, then random traffic
// checked every cycle against a timeline model of fires, busy windows and the rolling count.
module tb_trig_fire_sched;
    import trig_sched_pkg::*;

    localparam int NREQ = 4, P = 4, D = 20, RB = 4, CW = 8, MAXC = 8192;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef TRIG_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk_adc = 1'b0;
    logic reset;

    trig_fire_sched_if #(.NREQ(NREQ), .CNT_W(CW)) bus ();

    trig_fire_sched #(
        .NREQ(NREQ), .PULSE_TICKS(P), .DEAD_TICKS(D), .ROLL_BIT(RB), .CNT_W(CW)
    ) dut (
        .clk_adc (clk_adc),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 clk_adc = ~clk_adc;

    int n_cmp = 0, n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_adc);
        #2;
    endtask

    task automatic after_edge();
        @(posedge clk_adc);
        #3;
    endtask

    // ---------------- timeline model ----------------
    logic [NREQ-1:0] h_req[MAXC], h_en[MAXC];
    logic [31:0]     h_rand[MAXC], h_ps[MAXC];
    bit              h_rst[MAXC];
    int  cyc = 0, m_k;
    bit  model_valid = 1'b0;
    int  busy_last, last_fire, roll, m_fired, m_veto, m_pre;
    logic [2:0] m_src;
    bit  exp_ext, exp_busy, exp_fire_st;
    logic [2:0] exp_q[$];

    function automatic int sat(input int v);
        return (v >= CNT_MAX) ? CNT_MAX : v + 1;
    endfunction

    task automatic model_reset(input int k);
        model_valid = 1'b1;
        busy_last   = k - 1;
        last_fire   = -1000;
        roll        = 0;
        m_src       = 3'd0;
        m_fired     = 0;
        m_veto      = 0;
        m_pre       = 0;
        exp_q.delete();
    endtask

    task automatic model_fire(input int k, input logic [2:0] src);
        last_fire = k;
        busy_last = k + P + D - 1;
        m_src     = src;
        m_fired   = sat(m_fired);
        exp_q.push_back(src);
    endtask

    task automatic model_step(input int k);
        logic [NREQ-1:0] e;
        bit p;
        int w;
        e = h_rst[k-1] ? '0 : (h_req[k-2] & ~h_req[k-3] & h_en[k-1]);
        p = h_rst[k-1] ? 1'b0 : (h_rand[k-1] <= (h_rst[k-2] ? 32'd0 : h_ps[k-2]));
        if (k > busy_last + 1) begin
            if (e != '0) begin
                roll = 0;
                if (p) begin
                    w = 0;
                    for (int i = NREQ - 1; i >= 0; i--) if (e[i]) w = i;
                    model_fire(k, 3'(w));
                end else begin
                    busy_last = k + D - 1;
                    m_pre     = sat(m_pre);
                end
            end else if (roll == (1 << RB)) begin
                roll = 0;
                if (bus.dorolling) model_fire(k, 3'd7);
            end else begin
                roll++;
            end
        end else if (e != '0) begin
            m_veto = sat(m_veto);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_adc);
            m_k = cyc;
            if (m_k >= MAXC) begin
                $display("FAIL model_history: cycle %0d exceeds %0d", m_k, MAXC);
                $fatal(1);
            end
            h_req[m_k]  = bus.req;
            h_en[m_k]   = bus.req_en;
            h_rand[m_k] = bus.randnum;
            h_ps[m_k]   = bus.prescale;
            h_rst[m_k]  = reset;
            cyc++;
            if (reset) model_reset(m_k);
            else if (model_valid) model_step(m_k);
            exp_ext     = (m_k >= last_fire + 1) && (m_k <= last_fire + P);
            exp_fire_st = (m_k >= last_fire) && (m_k <= last_fire + P - 1);
            exp_busy    = (m_k <= busy_last);
        end
    end

    // ---------------- per-cycle compare + fire scoreboard ----------------
    int rise_cnt = 0, last_rise = 0, prev_rise = 0, neg_cnt = 0;
    bit prev_ext = 1'b0;

    initial begin
        logic [2:0] s;
        forever begin
            @(negedge clk_adc);
            neg_cnt++;
            if (model_valid) begin
                check("ext_trig_out", 64'(bus.ext_trig_out), 64'(exp_ext));
                check("busy", 64'(bus.busy), 64'(exp_busy));
                check("fire_src", 64'(bus.fire_src), 64'(m_src));
                check("state_fire", 64'(bus.dbg_state == FIRE), 64'(exp_fire_st));
                check("state_idle", 64'(bus.dbg_state == IDLE), 64'(!exp_busy));
                check("cnt_fired", 64'(bus.cnt_fired), STATS ? 64'(m_fired) : 64'd0);
                check("cnt_vetoed", 64'(bus.cnt_vetoed), STATS ? 64'(m_veto) : 64'd0);
                check("cnt_prescaled", 64'(bus.cnt_prescaled), STATS ? 64'(m_pre) : 64'd0);
                if (!prev_ext && bus.ext_trig_out) begin
                    rise_cnt++;
                    prev_rise = last_rise;
                    last_rise = neg_cnt;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL sb_unexpected_pulse: got pulse src %0d, expected none", bus.fire_src);
                    end else begin
                        s = exp_q.pop_front();
                        check("sb_fire_src", 64'(bus.fire_src), 64'(s));
                    end
                end
                prev_ext = bus.ext_trig_out;
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int r0, busy_n, idx;
        bit seen;
        reset = 1'b1;
        bus.req = '0; bus.req_en = '1; bus.randnum = 32'd0;
        bus.prescale = 32'hFFFF_FFFF; bus.dorolling = 1'b0;
        repeat (3) step();
        check("rst_ext", 64'(bus.ext_trig_out), 64'd0);
        check("rst_src", 64'(bus.fire_src), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_cnt_fired", 64'(bus.cnt_fired), 64'd0);
        reset = 1'b0;
        repeat (5) step();

        // 1: single request, pulse on edges N+3..N+6
        bus.req[1] = 1'b1;
        for (int j = 0; j <= 8; j++) begin
            after_edge();
            check("t1_pulse_window", 64'(bus.ext_trig_out), 64'((j >= 3) && (j <= 6)));
        end
        check("t1_src", 64'(bus.fire_src), 64'd1);
        check("t1_cnt_fired", 64'(bus.cnt_fired), STATS ? 64'd1 : 64'd0);
        repeat (30) step();
        bus.req = '0;
        repeat (5) step();

        // 2: simultaneous edges, lowest index wins, loser not counted
        r0 = rise_cnt;
        bus.req = 4'b0101;
        repeat (40) step();
        check("t2_one_pulse", 64'(rise_cnt - r0), 64'd1);
        check("t2_src", 64'(bus.fire_src), 64'd0);
        check("t2_cnt_vetoed", 64'(bus.cnt_vetoed), 64'd0);
        bus.req = '0;
        repeat (5) step();

        // 3: edge during holdoff is vetoed, edge after holdoff fires
        r0 = rise_cnt;
        bus.req[1] = 1'b1;
        repeat (8) step();
        bus.req[3] = 1'b1;
        repeat (10) step();
        check("t3_veto_no_pulse", 64'(rise_cnt - r0), 64'd1);
        check("t3_cnt_vetoed", 64'(bus.cnt_vetoed), STATS ? 64'd1 : 64'd0);
        bus.req[3] = 1'b0;
        repeat (8) step();
        bus.req[3] = 1'b1;
        repeat (40) step();
        check("t3_late_fires", 64'(rise_cnt - r0), 64'd2);
        check("t3_src", 64'(bus.fire_src), 64'd3);
        bus.req = '0;
        repeat (5) step();

        // 4: prescaled attempt still pays deadtime
        bus.prescale = 32'd0; bus.randnum = 32'd5;
        repeat (3) step();
        r0 = rise_cnt; busy_n = 0;
        bus.req[0] = 1'b1;
        for (int j = 0; j < 40; j++) begin
            after_edge();
            busy_n += int'(bus.busy);
        end
        check("t4_no_pulse", 64'(rise_cnt - r0), 64'd0);
        check("t4_busy_cycles", 64'(busy_n), 64'd20);
        check("t4_cnt_prescaled", 64'(bus.cnt_prescaled), STATS ? 64'd1 : 64'd0);
        bus.prescale = 32'hFFFF_FFFF; bus.req = '0;
        repeat (5) step();

        // 5: rolling trigger, 17 idle cycles + pulse + deadtime per period
        bus.dorolling = 1'b1;
        repeat (150) step();
        check("t5_roll_period", 64'(last_rise - prev_rise), 64'd41);
        check("t5_src", 64'(bus.fire_src), 64'd7);
        bus.dorolling = 1'b0;
        repeat (30) step();
        r0 = rise_cnt;
        repeat (100) step();
        check("t5_roll_off", 64'(rise_cnt - r0), 64'd0);

        // 6: reset two cycles into a pulse, held level must not refire
        bus.req[1] = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 10 && !seen; j++) begin
            after_edge();
            seen = bus.ext_trig_out;
        end
        check("t6_pulse_seen", 64'(seen), 64'd1);
        after_edge();
        reset = 1'b1;
        after_edge();
        check("t6_ext_dropped", 64'(bus.ext_trig_out), 64'd0);
        check("t6_busy", 64'(bus.busy), 64'd0);
        check("t6_cnt_fired", 64'(bus.cnt_fired), 64'd0);
        reset = 1'b0;
        r0 = rise_cnt;
        repeat (40) step();
        check("t6_no_refire", 64'(rise_cnt - r0), 64'd0);
        bus.req = '0;
        repeat (5) step();

        // random traffic
        for (int c = 0; c < 4000; c++) begin
            step();
            if ($urandom_range(0, 5) == 0) begin
                idx = $urandom_range(0, NREQ - 1);
                bus.req[idx] = ~bus.req[idx];
            end
            if ($urandom_range(0, 199) == 0) bus.req_en = 4'($urandom_range(0, 15));
            bus.randnum = $urandom;
            if (c % 500 == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.prescale = 32'hFFFF_FFFF;
                    1: bus.prescale = 32'd0;
                    2: bus.prescale = 32'h8000_0000;
                    default: bus.prescale = $urandom;
                endcase
            end
            if (c % 300 == 0) bus.dorolling = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 799) == 0);
        end

        reset = 1'b0; bus.req = '0; bus.dorolling = 1'b0;
        repeat (40) step();
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
